// File: rtl/branch_pred_pkg.sv
// rtl/branch_pred_pkg.sv - shared types, counter encodings and saturating update for the branch predictor
package branch_pred_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? ctr : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_target_table.sv
// rtl/branch_target_table.sv - BTB storage: combinational lookup port, synchronous train/allocate port
module branch_target_table
  import branch_pred_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ENTRIES    = 16,
  parameter int INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_hit,
  output logic [1:0]      rd_ctr,
  output logic [XLEN-1:0] rd_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int OFF_W = $clog2(INST_BYTES);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - OFF_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [XLEN-1:0]    target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];

  logic [IDX_W-1:0] rd_idx, upd_idx;
  logic [TAG_W-1:0] rd_tag, upd_tag;
  logic             upd_hit;

  assign rd_idx  = rd_pc[OFF_W +: IDX_W];
  assign rd_tag  = rd_pc[XLEN-1 -: TAG_W];
  assign upd_idx = upd_pc[OFF_W +: IDX_W];
  assign upd_tag = upd_pc[XLEN-1 -: TAG_W];

  // Offset bits below the instruction size never select an entry.
  logic unused_pc;
  assign unused_pc = ^{rd_pc, upd_pc};

  assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_ctr    = rd_hit ? ctr_mem[rd_idx] : CTR_SNT;
  assign rd_target = rd_hit ? target_mem[rd_idx] : '0;
  assign upd_hit   = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);

  // No write-to-read bypass: a same-cycle lookup sees the old entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (upd_en) begin
      if (upd_hit) begin
        ctr_mem[upd_idx] <= ctr_update(ctr_mem[upd_idx], upd_taken);
        if (upd_taken) target_mem[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid[upd_idx]      <= 1'b1;
        tag_mem[upd_idx]    <= upd_tag;
        target_mem[upd_idx] <= upd_target;
        ctr_mem[upd_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_predict.sv
// rtl/branch_resolve_predict.sv - next-PC decision: BTB prediction, mispredict redirect/flush, statistics
module branch_resolve_predict
  import branch_pred_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BTB_ENTRIES  = 16,
  parameter int INST_BYTES   = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             res_valid,
  input  logic [XLEN-1:0]  res_pc,
  input  logic             res_taken,
  input  logic [XLEN-1:0]  res_target,
  input  logic             res_pred_taken,
  input  logic [XLEN-1:0]  res_pred_target,
  output logic [XLEN-1:0]  pc_new,
  output logic             take_new_pc,
  output logic             flush_pipeline,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t            state, next_state;
  logic [FC_W-1:0]   flush_cnt, next_cnt;
  logic              next_take;
  logic [XLEN-1:0]   next_pc;
  logic              lookup_hit;
  logic [1:0]        lookup_ctr;
  logic              accept, mispredict;

  branch_target_table #(
    .XLEN       (XLEN),
    .ENTRIES    (BTB_ENTRIES),
    .INST_BYTES (INST_BYTES)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_pc      (fetch_pc),
    .rd_hit     (lookup_hit),
    .rd_ctr     (lookup_ctr),
    .rd_target  (pred_target),
    .upd_en     (accept),
    .upd_pc     (res_pc),
    .upd_taken  (res_taken),
    .upd_target (res_target)
  );

  assign pred_taken = lookup_hit && lookup_ctr[1];

  // Resolves seen during FLUSH belong to the squashed wrong path.
  assign accept     = res_valid && (state == ST_IDLE);
  assign mispredict = accept && ((res_taken != res_pred_taken) ||
                                 (res_taken && res_pred_taken && (res_target != res_pred_target)));

  always_comb begin
    next_state = state;
    next_cnt   = flush_cnt;
    next_take  = 1'b0;
    next_pc    = pc_new;
    case (state)
      ST_IDLE: begin
        if (mispredict) begin
          next_state = ST_FLUSH;
          next_cnt   = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == '0) next_state = ST_IDLE;
        else                 next_cnt   = flush_cnt - 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
    if (mispredict) begin
      next_take = 1'b1;
      next_pc   = res_taken ? res_target : res_pc + XLEN'(INST_BYTES);
    end else if (fetch_valid && pred_taken) begin
      next_take = 1'b1;
      next_pc   = pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      flush_cnt        <= '0;
      pc_new           <= '0;
      take_new_pc      <= 1'b0;
      flush_pipeline   <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      state          <= next_state;
      flush_cnt      <= next_cnt;
      pc_new         <= next_pc;
      take_new_pc    <= next_take;
      flush_pipeline <= (next_state == ST_FLUSH);
      if (accept && (branch_count != '1))
        branch_count <= branch_count + 1'b1;
      if (mispredict && (mispredict_count != '1))
        mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule

// File: doc/branch_resolve_predict.md
# branch_resolve_predict

Parametrised next-PC decision unit with an integrated branch target buffer (BTB) and 2-bit saturating-counter predictor. It sits between fetch and the execute-stage branch resolution logic. It serves fetch-time predictions, detects mispredictions (wrong direction or wrong target) at resolve time, and issues registered redirects with a multi-cycle flush. It also trains the predictor table and keeps branch and mispredict statistics.

## Interface
Parameters:
- XLEN, 32, PC/address width
- BTB_ENTRIES, 16, table depth; power of 2, ≥2; IDX_W = log2(BTB_ENTRIES)
- INST_BYTES, 4, instruction size; fall-through = pc + INST_BYTES; power of 2
- FLUSH_CYCLES, 2, cycles flush_pipeline stays high per mispredict; ≥1
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- fetch_valid  in  1  fetch_pc is a live fetch address
- fetch_pc  in  XLEN  current fetch PC
- pred_taken  out  1  combinational: BTB hit and counter[1]==1
- pred_target  out  XLEN  combinational: hit entry target, else 0
- res_valid  in  1  a branch resolves this cycle
- res_pc  in  XLEN  PC of the resolving branch
- res_taken  in  1  actual branch outcome
- res_target  in  XLEN  actual target from the address builder
- res_pred_taken  in  1  prediction carried down the pipeline
- res_pred_target  in  XLEN  predicted target carried down the pipeline
- pc_new  out  XLEN  registered redirect PC
- take_new_pc  out  1  registered; fetch loads pc_new this cycle
- flush_pipeline  out  1  registered; squash younger instructions
- branch_count  out  CNT_W  accepted resolves; saturating
- mispredict_count  out  CNT_W  mispredicts; saturating

## Operation
- **Index and tag.** index = pc[IDX_W+log2(INST_BYTES)-1 : log2(INST_BYTES)]. tag = the remaining upper PC bits.
- **Entry contents.** valid, tag, target[XLEN], ctr[2]. Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
- **Lookup.** Purely combinational on fetch_pc. A hit requires valid and a tag match.
- **FSM states:** IDLE and FLUSH.
  - Resolves are accepted only in IDLE.
  - Resolves arriving in FLUSH are wrong-path. They are ignored: no training, no counters, no redirect.
- **Mispredict condition** (accepted resolve):
  - res_taken != res_pred_taken, or
  - res_taken && res_pred_taken && res_target != res_pred_target.
- **Mispredict response** (next edge):
  - pc_new = res_taken ? res_target : res_pc + INST_BYTES, with modulo-2^XLEN wrap.
  - take_new_pc = 1, flush_pipeline = 1.
  - Flush counter loads FLUSH_CYCLES-1; go to FLUSH.
  - In FLUSH, decrement each cycle; return to IDLE when the counter is 0. flush_pipeline is high for exactly FLUSH_CYCLES cycles.
- **Predicted redirect.** When there is no mispredict this cycle, fetch_valid && pred_taken registers pc_new = pred_target and take_new_pc = 1, with flush_pipeline unchanged.
  - Allowed in IDLE and in FLUSH.
  - Mispredict always has priority.
  - Otherwise take_new_pc = 0 and pc_new holds its previous value.
- **Training** (accepted resolve, hit or miss):
  - Hit: ctr saturating increment if taken, decrement if not. If taken, target = res_target.
  - Miss and taken: allocate the entry, overwriting: valid=1, tag, target=res_target, ctr=WT.
  - Miss and not taken: no write.
- **Read/write collision.** Lookup and update on the same index in the same cycle: the lookup returns the old entry (no bypass).
- **Statistics.** branch_count +1 per accepted resolve. mispredict_count +1 per mispredict. Both saturate at all-ones.

## Timing
- **Reset** (rst_n=0 at an edge):
  - pc_new=0, take_new_pc=0, flush_pipeline=0, both counters=0.
  - State IDLE, flush counter 0, all valid bits cleared in the same cycle.
  - Consequently pred_taken=0 and pred_target=0 from the first post-reset cycle.
- **Reset mid-FLUSH** aborts the flush immediately. No residual flush cycles.
- **Latency:**
  - Resolve to redirect/flush: 1 cycle.
  - fetch_pc to predicted redirect: 1 cycle.
  - Table update is visible to lookups 1 cycle after the resolve.
- **Back-to-back mispredicts.** The second mispredict is ignored if it falls inside the FLUSH window. It is accepted on the first IDLE cycle after the window.
- **take_new_pc** is a single-cycle pulse per event. Consecutive predicted redirects may pulse on consecutive cycles.

## Structure
- **Package branch_pred_pkg:** FSM state encoding, counter encodings SNT/WNT/WT/ST, and the saturating-update function.
- **Sub-module branch_target_table:** entry storage with one combinational read port, one synchronous write port, and synchronous clear on rst_n.
- **Top level:** decision logic, FSM, and statistics counters.

## Test plan
- **Reset then lookup.** Reset, then fetch_pc=0x100 with fetch_valid=1 → pred_taken=0, take_new_pc stays 0, counters 0.
- **Allocate and predict.** Resolve pc=0x100, taken, target=0x200, pred_taken=0 → next cycle pc_new=0x200, take_new_pc=1, flush high 2 cycles, mispredict_count=1. Then fetch_pc=0x100 → pred_taken=1, pred_target=0x200, redirect the following cycle.
- **Taken wrongly predicted.** Resolve pc=0x100, taken=0, pred_taken=1 → pc_new=0x104, flush 2 cycles. Ctr goes WT→WNT and pred_taken becomes 0 next cycle.
- **Target mismatch.** Resolve pc=0x100, both taken, res_target=0x300, pred_target=0x200 → pc_new=0x300, entry target becomes 0x300.
- **Wrong-path resolve and priority.** A second mispredicting resolve one cycle into FLUSH → ignored; counters unchanged. A same-cycle predicted hit and mispredict → pc_new is the mispredict target.
- **Reset mid-FLUSH and wrap/saturation.** Reset asserted during FLUSH → flush_pipeline=0 next cycle, table empty. Resolve not-taken at res_pc=0xFFFFFFFC → pc_new=0x00000000. With CNT_W=2, 4 mispredicts → counter holds at 3.
